led_pattern_gen: RTL and testbench
==================================

// Module: led_pattern_gen
// PURPOSE
//   Parametrised LED pattern engine driving an N-wide LED bank from a programmable tick.
//   Supersedes the fixed 10-LED bouncer.
//   Adds: generic width, run-time speed select, four pattern modes, and pause/single-step for bring-up.
//   Sits between board clock/reset and the LED pins; all control inputs come from switches/regs.
// PARAMETERS
//   N_LEDS   10          LED count; must be >= 2
//   CLK_DIV  25_000_000  clk_i cycles per step at speed_i=0
//   SPD_W    2           width of speed_i; step period = max(1, CLK_DIV >> speed_i)
// PORTS
//   clk_i    in   1        single system clock, all logic on posedge
//   rst_i    in   1        asynchronous, active-high reset
//   mode_i   in   2        0=BOUNCE 1=ROT_L 2=ROT_R 3=BAR
//   speed_i  in   SPD_W    step-rate select, larger = faster
//   pause_i  in   1        1 = freeze divider and pattern
//   step_i   in   1        1-cycle pulse; advances one step only while pause_i=1
//   led_o    out  N_LEDS   registered LED pattern
//   dir_o    out  1        registered; 0 = up (toward MSB), 1 = down
//   tick_o   out  1        registered 1-cycle pulse, high in first cycle of each new pattern
// BEHAVIOUR
//   Reset (async, immediate):
//     - led_o=1, dir_o=0, tick_o=0
//     - divider count=0, registered mode=BOUNCE
//     - release is synchronous to next posedge
//   Divider:
//     - limit L = max(1, CLK_DIV>>speed_i)
//     - count runs 0..L-1; strobe when count==L-1, then count<=0
//     - if speed_i change leaves count>=L: count<=0 next edge, no strobe that edge
//     - pause_i=1 holds count, no strobe
//   Advance event:
//     - strobe (not paused), or step_i=1 while pause_i=1
//     - step_i while pause_i=0 is ignored
//   On an advance edge:
//     - led_o/dir_o take next pattern
//     - tick_o<=1 for exactly one cycle; latency strobe->new led_o = 1 edge
//   Mode change:
//     - mode_i != registered mode at an edge: reload instead of advance (reload wins over strobe/step)
//     - mode register<=mode_i; count<=0; tick_o<=0
//     - led_o<=start value; dir_o<=start dir
//     - start values: BOUNCE/ROT_L/BAR -> led=1, dir=0; ROT_R -> led=1<<(N_LEDS-1), dir=1
//   BOUNCE (one-hot):
//     - dir=0: at MSB, go led>>1 with dir<=1; else led<<1
//     - dir=1: at bit0, go led<<1 with dir<=0; else led>>1
//     - endpoints shown for exactly one step; never all-zero, never repeats an endpoint
//   ROT_L: rotate left, MSB wraps to bit0; dir_o=0 constant.
//   ROT_R: rotate right, bit0 wraps to MSB; dir_o=1 constant.
//   BAR (thermometer):
//     - dir=0: led<=(led<<1)|1; at all-ones go led>>1, dir<=1
//     - dir=1: led>>1; at led==1 go 3, dir<=0
//   Illegal led_o state (not one-hot in one-hot mode, or not thermometer in BAR): next advance reloads the mode's start value.
//   Width rules:
//     - count sized $clog2(CLK_DIV)+1
//     - shifts truncated to N_LEDS bits
//     - no X on any output after reset
// STRUCTURE
//   led_pkg: mode encodings (MODE_BOUNCE..MODE_BAR), DIR_UP/DIR_DN, start-value function.
//   Sub-module tick_div:
//     - prescaler with count, limit calc, speed-change restart, pause hold
//     - outputs strobe
//   Top holds mode register, pattern/dir regs, next-pattern logic.
// TESTING (N_LEDS=10, CLK_DIV=4, SPD_W=2 unless stated)
//   1. Reset, mode=0, speed=0
//      -> led_o 0x001,0x002..0x200,0x100..0x001,0x002, one step per 4 clks
//      -> dir_o flips on edges producing 0x100 and 0x002
//   2. ROT_L from reload -> ..0x100,0x200,0x001
//      ROT_R -> 0x200..0x001,0x200; dir_o constant 0 / 1
//   3. BAR -> 0x001,0x003,..,0x3FF,0x1FF,..,0x001,0x003; dir_o=1 from 0x1FF through 0x001
//   4. speed=2 -> step every clk
//      speed 0->1 with count=3 -> count restarts at 0, no tick that edge; next tick 2 clks later
//   5. pause=1 for 100 clks -> led_o/tick_o frozen
//      step_i pulse -> exactly one advance + one tick_o next edge
//      step_i with pause=0 -> no extra advance
//   6. Mode change -> start value next edge, even if strobe coincides
//      rst_i pulse mid-BAR -> led_o=0x001, dir_o=0 without waiting for a clock edge

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern engine: mode encodings, direction
// encodings and the per-mode start state.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'd0,
        MODE_ROT_L  = 2'd1,
        MODE_ROT_R  = 2'd2,
        MODE_BAR    = 2'd3
    } mode_e;

    localparam logic DIR_UP = 1'b0;  // toward MSB
    localparam logic DIR_DN = 1'b1;  // toward bit 0

    // Bit position of the single lit LED in a mode's start pattern.
    function automatic int unsigned start_bit(input mode_e m, input int unsigned n_leds);
        return (m == MODE_ROT_R) ? (n_leds - 1) : 0;
    endfunction

    // Direction flag that accompanies a mode's start pattern.
    function automatic logic start_dir(input mode_e m);
        return (m == MODE_ROT_R) ? DIR_DN : DIR_UP;
    endfunction

endpackage

// File: rtl/tick_div.sv
// Step-rate prescaler: counts 0..L-1 with L = max(1, CLK_DIV >> speed_i),
// strobing on the last count. Restarts cleanly when a speed change leaves
// the count out of range, holds while paused, and can be cleared externally.
module tick_div #(
    parameter int unsigned CLK_DIV = 25_000_000,
    parameter int unsigned SPD_W   = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [SPD_W-1:0] speed_i,
    input  logic             pause_i,
    input  logic             clear_i,
    output logic             strobe_c_o
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV) + 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] last;

    // Current period limit, clamped so the fastest setting still steps every clock.
    always_comb begin
        limit = CNT_W'(CLK_DIV) >> speed_i;
        if (limit == '0) begin
            limit = CNT_W'(1);
        end
        last = limit - CNT_W'(1);
    end

    // Next count and strobe; out-of-range restart never strobes.
    always_comb begin
        count_d    = count_q;
        strobe_c_o = 1'b0;
        if (clear_i) begin
            count_d = '0;
        end else if (pause_i) begin
            count_d = count_q;
        end else if (count_q >= limit) begin
            count_d = '0;
        end else if (count_q == last) begin
            count_d    = '0;
            strobe_c_o = 1'b1;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: bounce, rotate-left, rotate-right and bar-graph patterns
// on an N-wide LED bank, stepped by a programmable prescaler with pause and
// single-step for bring-up.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int unsigned N_LEDS  = 10,
    parameter int unsigned CLK_DIV = 25_000_000,
    parameter int unsigned SPD_W   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        mode_i,
    input  logic [SPD_W-1:0]  speed_i,
    input  logic              pause_i,
    input  logic              step_i,
    output logic [N_LEDS-1:0] led_o,
    output logic              dir_o,
    output logic              tick_o
);

    localparam logic [N_LEDS-1:0] LED_ONE   = N_LEDS'(1);
    localparam logic [N_LEDS-1:0] LED_THREE = N_LEDS'(3);
    localparam logic [N_LEDS-1:0] LED_ALL   = {N_LEDS{1'b1}};

    mode_e             mode_q, mode_d, mode_in;
    logic [N_LEDS-1:0] led_q, led_d, nxt_led;
    logic              dir_q, dir_d, nxt_dir;
    logic              tick_q, tick_d;
    logic              mode_chg_c;
    logic              strobe_c;
    logic              advance_c;
    logic              onehot_ok_c;
    logic              therm_ok_c;

    // A mode change restarts the divider so the new pattern gets a full first step.
    tick_div #(
        .CLK_DIV (CLK_DIV),
        .SPD_W   (SPD_W)
    ) u_tick_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .speed_i    (speed_i),
        .pause_i    (pause_i),
        .clear_i    (mode_chg_c),
        .strobe_c_o (strobe_c)
    );

    // Decode control: mode change detect and advance qualification.
    always_comb begin
        mode_in    = mode_e'(mode_i);
        mode_chg_c = (mode_in != mode_q);
        advance_c  = strobe_c | (pause_i & step_i);
    end

    // Pattern that follows the current one in the registered mode; illegal states reload.
    always_comb begin
        onehot_ok_c = (led_q != '0) && ((led_q & (led_q - LED_ONE)) == '0);
        therm_ok_c  = (led_q != '0) && ((led_q & (led_q + LED_ONE)) == '0);
        nxt_led     = LED_ONE << start_bit(mode_q, N_LEDS);
        nxt_dir     = start_dir(mode_q);
        case (mode_q)
            MODE_BOUNCE: begin
                if (onehot_ok_c) begin
                    if (dir_q == DIR_UP) begin
                        if (led_q[N_LEDS-1]) begin
                            nxt_led = led_q >> 1;
                            nxt_dir = DIR_DN;
                        end else begin
                            nxt_led = led_q << 1;
                            nxt_dir = DIR_UP;
                        end
                    end else begin
                        if (led_q[0]) begin
                            nxt_led = led_q << 1;
                            nxt_dir = DIR_UP;
                        end else begin
                            nxt_led = led_q >> 1;
                            nxt_dir = DIR_DN;
                        end
                    end
                end
            end
            MODE_ROT_L: begin
                if (onehot_ok_c) begin
                    nxt_led = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
                    nxt_dir = DIR_UP;
                end
            end
            MODE_ROT_R: begin
                if (onehot_ok_c) begin
                    nxt_led = {led_q[0], led_q[N_LEDS-1:1]};
                    nxt_dir = DIR_DN;
                end
            end
            MODE_BAR: begin
                if (therm_ok_c) begin
                    if (dir_q == DIR_UP) begin
                        if (led_q == LED_ALL) begin
                            nxt_led = led_q >> 1;
                            nxt_dir = DIR_DN;
                        end else begin
                            nxt_led = (led_q << 1) | LED_ONE;
                            nxt_dir = DIR_UP;
                        end
                    end else begin
                        if (led_q == LED_ONE) begin
                            nxt_led = LED_THREE;
                            nxt_dir = DIR_UP;
                        end else begin
                            nxt_led = led_q >> 1;
                            nxt_dir = DIR_DN;
                        end
                    end
                end
            end
            default: begin
                nxt_led = LED_ONE;
                nxt_dir = DIR_UP;
            end
        endcase
    end

    // Register update: reload on mode change takes priority over any advance.
    always_comb begin
        mode_d = mode_q;
        led_d  = led_q;
        dir_d  = dir_q;
        tick_d = 1'b0;
        if (mode_chg_c) begin
            mode_d = mode_in;
            led_d  = LED_ONE << start_bit(mode_in, N_LEDS);
            dir_d  = start_dir(mode_in);
        end else if (advance_c) begin
            led_d  = nxt_led;
            dir_d  = nxt_dir;
            tick_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q <= MODE_BOUNCE;
            led_q  <= LED_ONE;
            dir_q  <= DIR_UP;
            tick_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            led_q  <= led_d;
            dir_q  <= dir_d;
            tick_q <= tick_d;
        end
    end

    assign led_o  = led_q;
    assign dir_o  = dir_q;
    assign tick_o = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with N_LEDS=10, CLK_DIV=4, SPD_W=2.
module tb_led_pattern_gen;

    localparam int unsigned N  = 10;
    localparam int unsigned CD = 4;
    localparam int unsigned SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic [SW-1:0] speed;
    logic          pause;
    logic          step;
    logic [N-1:0]  led;
    logic          dir;
    logic          tick;

    typedef struct {
        logic [1:0]    mode;
        logic [SW-1:0] speed;
        logic          pause;
        logic          step;
        logic [N-1:0]  led;
        logic          dir;
        logic          tick;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .N_LEDS  (N),
        .CLK_DIV (CD),
        .SPD_W   (SW)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .mode_i  (mode),
        .speed_i (speed),
        .pause_i (pause),
        .step_i  (step),
        .led_o   (led),
        .dir_o   (dir),
        .tick_o  (tick)
    );

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input int m, input int sp, input int p, input int s,
                       input int ld, input int d, input int t);
        vec_t v;
        v.mode  = 2'(m);
        v.speed = SW'(sp);
        v.pause = 1'(p);
        v.step  = 1'(s);
        v.led   = N'(ld);
        v.dir   = 1'(d);
        v.tick  = 1'(t);
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int frozen_bad;

        // speed=2 gives one step per clock; each entry is the state after one edge
        for (int i = 1; i <= 9; i++) add(0, 2, 0, 0, 1 << i, 0, 1);
        for (int i = 8; i >= 0; i--) add(0, 2, 0, 0, 1 << i, 1, 1);
        add(0, 2, 0, 0, 'h002, 0, 1);
        add(1, 2, 0, 0, 'h001, 0, 0);
        for (int i = 1; i <= 9; i++) add(1, 2, 0, 0, 1 << i, 0, 1);
        add(1, 2, 0, 0, 'h001, 0, 1);
        add(2, 2, 0, 0, 'h200, 1, 0);
        for (int i = 8; i >= 0; i--) add(2, 2, 0, 0, 1 << i, 1, 1);
        add(2, 2, 0, 0, 'h200, 1, 1);
        add(3, 2, 0, 0, 'h001, 0, 0);
        for (int i = 2; i <= 10; i++) add(3, 2, 0, 0, (1 << i) - 1, 0, 1);
        for (int i = 9; i >= 1; i--) add(3, 2, 0, 0, (1 << i) - 1, 1, 1);
        add(3, 2, 0, 0, 'h003, 0, 1);
        add(3, 2, 1, 0, 'h003, 0, 0);
        add(3, 2, 1, 1, 'h007, 0, 1);
        add(3, 2, 1, 0, 'h007, 0, 0);
        add(3, 2, 0, 1, 'h00F, 0, 1);

        // reset state
        rst = 1'b1; mode = 2'd0; speed = SW'(2); pause = 1'b0; step = 1'b0;
        #3;
        chk("rst_led",  0, 32'(led),  32'h001);
        chk("rst_dir",  0, 32'(dir),  32'h0);
        chk("rst_tick", 0, 32'(tick), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // table-driven pattern walk
        for (int k = 0; k < vecs.size(); k++) begin
            mode  = vecs[k].mode;
            speed = vecs[k].speed;
            pause = vecs[k].pause;
            step  = vecs[k].step;
            @(posedge clk);
            #1;
            chk("vec_led",  k, 32'(led),  32'(vecs[k].led));
            chk("vec_dir",  k, 32'(dir),  32'(vecs[k].dir));
            chk("vec_tick", k, 32'(tick), 32'(vecs[k].tick));
            @(negedge clk);
        end

        // speed 0: one step per 4 clocks
        step = 1'b0; pause = 1'b0; speed = SW'(0);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            chk("slow_hold", i, 32'(led), 32'h00F);
            chk("slow_tick", i, 32'(tick), 32'h0);
        end
        @(posedge clk); #1;
        chk("slow_step_led",  0, 32'(led),  32'h01F);
        chk("slow_step_tick", 0, 32'(tick), 32'h1);

        // run count up to 3, then speed 0->1 forces a restart without a strobe
        @(posedge clk); #1;
        chk("tick_pulse_end", 0, 32'(tick), 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        speed = SW'(1);
        @(posedge clk); #1;
        chk("spd_restart_led",  0, 32'(led),  32'h01F);
        chk("spd_restart_tick", 0, 32'(tick), 32'h0);
        @(posedge clk); #1;
        chk("spd_wait_tick", 0, 32'(tick), 32'h0);
        @(posedge clk); #1;
        chk("spd_next_led",  0, 32'(led),  32'h03F);
        chk("spd_next_tick", 0, 32'(tick), 32'h1);

        // pause for 100 clocks: nothing moves
        @(negedge clk);
        pause = 1'b1;
        frozen_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (led !== N'('h03F) || tick !== 1'b0) frozen_bad++;
        end
        chk("pause_frozen", 0, 32'(frozen_bad), 32'h0);

        // single step while paused
        @(negedge clk);
        step = 1'b1;
        @(posedge clk); #1;
        chk("step_led",  0, 32'(led),  32'h07F);
        chk("step_tick", 0, 32'(tick), 32'h1);
        @(negedge clk);
        step = 1'b0;
        @(posedge clk); #1;
        chk("step_once_led",  0, 32'(led),  32'h07F);
        chk("step_once_tick", 0, 32'(tick), 32'h0);

        // step while running is ignored; divider resumes from its held count
        @(negedge clk);
        pause = 1'b0; step = 1'b1;
        @(posedge clk); #1;
        chk("step_ign_led",  0, 32'(led),  32'h07F);
        chk("step_ign_tick", 0, 32'(tick), 32'h0);
        @(negedge clk);
        step = 1'b0;
        @(posedge clk); #1;
        chk("resume_led",  0, 32'(led),  32'h0FF);
        chk("resume_tick", 0, 32'(tick), 32'h1);

        // async reset mid-BAR, observed before any clock edge
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_led",  0, 32'(led),  32'h001);
        chk("async_rst_dir",  0, 32'(dir),  32'h0);
        chk("async_rst_tick", 0, 32'(tick), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_reload_led",  0, 32'(led),  32'h001);
        chk("post_rst_reload_tick", 0, 32'(tick), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
